// File: rtl/rgb_serial_comparator.sv
// Bit-serial MSB-first magnitude comparator driving the board RGB LED.
// red = a>=b, green = a<=b, blue = a!=b, latched when a compare completes.
module rgb_serial_comparator #(
    parameter int WIDTH     = 8,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             red,
    output logic             green,
    output logic             blue
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sh_a, sh_b;
    logic [CW-1:0]    cnt;
    logic             sgn, gt, lt;
    logic             gt_nxt, lt_nxt;
    logic             load, last;
    logic             a_bit, b_bit, sign_bit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                busy = 1'b1;
                if (cnt == '0) begin
                    last      = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // First differing bit decides; the sign bit flips polarity in signed mode.
    always_comb begin
        a_bit    = sh_a[WIDTH-1];
        b_bit    = sh_b[WIDTH-1];
        sign_bit = sgn && (cnt == CNT_MAX);
        gt_nxt   = gt;
        lt_nxt   = lt;
        if (!gt && !lt && (a_bit != b_bit)) begin
            if (a_bit ^ sign_bit) gt_nxt = 1'b1;
            else                  lt_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            sgn   <= 1'b0;
            gt    <= 1'b0;
            lt    <= 1'b0;
            red   <= 1'b0;
            green <= 1'b0;
            blue  <= 1'b0;
        end else if (load) begin
            sh_a <= a;
            sh_b <= b;
            sgn  <= SIGNED_EN ? signed_mode : 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
            cnt  <= CNT_MAX;
        end else if (busy) begin
            sh_a <= sh_a << 1;
            sh_b <= sh_b << 1;
            cnt  <= cnt - 1'b1;
            gt   <= gt_nxt;
            lt   <= lt_nxt;
            // LEDs take the flags including the bit-0 decision made this edge.
            if (last) begin
                red   <= ~lt_nxt;
                green <= ~gt_nxt;
                blue  <= gt_nxt | lt_nxt;
            end
        end
    end
endmodule

// File: tb/tb_rgb_serial_comparator.sv
// Directed and randomized checks of rgb_serial_comparator against an
// arithmetic reference of the a>=b / a<=b / a!=b rules.
module tb_rgb_serial_comparator;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start8 = 1'b0, start2 = 1'b0, sm = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic [1:0] a2 = '0, b2 = '0;

    logic busy8s, done8s, r8s, g8s, bl8s;
    logic busy8u, done8u, r8u, g8u, bl8u;
    logic busy2, done2, r2, g2, bl2;
    logic [2:0] leds8s, leds8u, leds2;
    logic [2:0] prev8s, prev8u, prev2;

    int tests = 0;
    int fails = 0;

    assign leds8s = {r8s, g8s, bl8s};
    assign leds8u = {r8u, g8u, bl8u};
    assign leds2  = {r2, g2, bl2};

    always #5 clk = ~clk;

    rgb_serial_comparator #(.WIDTH(8), .SIGNED_EN(1'b1)) u8s (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm), .a(a8), .b(b8),
        .busy(busy8s), .done(done8s), .red(r8s), .green(g8s), .blue(bl8s));

    rgb_serial_comparator #(.WIDTH(8), .SIGNED_EN(1'b0)) u8u (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm), .a(a8), .b(b8),
        .busy(busy8u), .done(done8u), .red(r8u), .green(g8u), .blue(bl8u));

    rgb_serial_comparator #(.WIDTH(2), .SIGNED_EN(1'b1)) u2 (
        .clk(clk), .reset(reset), .start(start2), .signed_mode(sm), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .red(r2), .green(g2), .blue(bl2));

    function automatic logic [2:0] ref_cmp(input logic [31:0] x, input logic [31:0] y,
                                           input int w, input bit sgn);
        longint vx, vy;
        vx = {32'b0, x};
        vy = {32'b0, y};
        if (sgn && x[w-1]) vx = vx - (longint'(1) << w);
        if (sgn && y[w-1]) vy = vy - (longint'(1) << w);
        return {vx >= vy, vx <= vy, vx != vy};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input bit tsm,
                        input bit disturb);
        logic [2:0] e_s, e_u;
        e_s = ref_cmp(32'(ta), 32'(tb), 8, tsm);
        e_u = ref_cmp(32'(ta), 32'(tb), 8, 1'b0);
        @(negedge clk);
        a8 = ta; b8 = tb; sm = tsm; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("busy_e0", 32'({busy8s, busy8u, done8s}), 32'b110);
        for (int k = 1; k < 8; k++) begin
            @(posedge clk); #1;
            if (disturb && k == 3) begin
                start8 = 1'b1; a8 = ~ta; b8 = 8'($urandom); sm = ~tsm;
            end
            if (disturb && k == 4) start8 = 1'b0;
            chk("busy_mid", 32'({busy8s, done8s}), 32'b10);
            chk("led_hold_s", 32'(leds8s), 32'(prev8s));
            chk("led_hold_u", 32'(leds8u), 32'(prev8u));
        end
        @(posedge clk); #1;
        chk("done_pulse", 32'({busy8s, done8s, busy8u, done8u}), 32'b0101);
        chk("result_s", 32'(leds8s), 32'(e_s));
        chk("result_u", 32'(leds8u), 32'(e_u));
        prev8s = e_s;
        prev8u = e_u;
        @(posedge clk); #1;
        chk("done_end", 32'({busy8s, done8s}), 32'b00);
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tb);
        logic [2:0] e;
        e = ref_cmp(32'(ta), 32'(tb), 2, 1'b0);
        @(negedge clk);
        a2 = ta; b2 = tb; sm = 1'b0; start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        chk("w2_busy0", 32'({busy2, done2}), 32'b10);
        @(posedge clk); #1;
        chk("w2_busy1", 32'({busy2, done2}), 32'b10);
        chk("w2_hold", 32'(leds2), 32'(prev2));
        @(posedge clk); #1;
        chk("w2_done", 32'({busy2, done2}), 32'b01);
        chk("w2_result", 32'(leds2), 32'(e));
        prev2 = e;
        @(posedge clk); #1;
        chk("w2_done_end", 32'(done2), 32'd0);
    endtask

    initial begin
        int n_done, t0, t1;
        prev8s = '0; prev8u = '0; prev2 = '0;
        #1;
        chk("reset_8s", 32'({busy8s, done8s, leds8s}), 32'd0);
        chk("reset_2", 32'({busy2, done2, leds2}), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        run8(8'h80, 8'h7F, 1'b0, 1'b0);
        run8(8'h80, 8'h7F, 1'b1, 1'b0);
        run8(8'h5A, 8'h5A, 1'b0, 1'b0);
        run8(8'h00, 8'hFF, 1'b0, 1'b0);
        run8(8'h3C, 8'hC3, 1'b1, 1'b1);
        run8(8'hF0, 8'h0F, 1'b0, 1'b1);

        // Held start: done must recur every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; sm = 1'b0; start8 = 1'b1;
        n_done = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 40 && n_done < 2; c++) begin
            @(posedge clk); #1;
            if (done8s) begin
                if (n_done == 0) t0 = c; else t1 = c;
                n_done++;
            end
        end
        chk("held_count", 32'(n_done), 32'd2);
        chk("held_period", 32'(t1 - t0), 32'd10);
        chk("held_result", 32'(leds8s), 32'(ref_cmp(32'h12, 32'h34, 8, 1'b0)));
        prev8s = ref_cmp(32'h12, 32'h34, 8, 1'b0);
        prev8u = prev8s;
        @(negedge clk);
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("held_idle", 32'({busy8s, done8s}), 32'b00);

        run8(8'hA5, 8'hA5, 1'b1, 1'b0);

        // Asynchronous reset mid-compare.
        @(negedge clk);
        a8 = 8'h01; b8 = 8'h02; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", 32'({busy8s, done8s, leds8s, busy8u, leds8u}), 32'd0);
        prev8s = '0; prev8u = '0; prev2 = '0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("reset_no_done", 32'({done8s, done8u}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_idle", 32'({busy8s, done8s}), 32'd0);
        run8(8'h02, 8'h01, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++)
            run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        for (int i = 0; i < 16; i++)
            run2(2'(i >> 2), 2'(i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
